// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit and its return-address stack.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetchState_t;

    localparam int RAS_DEPTH    = 4;
    localparam int JUMP_INDEX_W = 26;   // J-format target field
    localparam int JUMP_HI_W    = 4;    // upper pc_plus4 bits kept by J/JAL
    localparam int BRANCH_IMM_W = 16;   // branch immediate, in words

    // Word-granular branch immediate to a signed 32-bit byte offset.
    function automatic logic [31:0] branchOffset(input logic [BRANCH_IMM_W-1:0] imm);
        return {{(32 - BRANCH_IMM_W - 2){imm[BRANCH_IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// Return-address stack: circular LIFO that overwrites its oldest entry when pushed while full.
// Latency: top is combinational from storage; push/pop take effect on the next rising clk.
// Backpressure: none; a pop of an empty stack is ignored, push+pop together replaces the top.
module fetch_ras
    import fetch_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] pushData,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] topPtr;
    logic [CNT_W-1:0] count;
    logic             popOk;

    assign popOk = pop && !empty;
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign top   = mem[topPtr];

    // Pointer and occupancy; the pointer wraps so a full push drops the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            topPtr <= '0;
            count  <= '0;
        end else if (push && popOk) begin
            topPtr <= topPtr;
        end else if (push) begin
            topPtr <= topPtr + PTR_W'(1);
            if (count != CNT_MAX) count <= count + CNT_W'(1);
        end else if (popOk) begin
            topPtr <= topPtr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push && popOk)  mem[topPtr]              <= pushData;
        else if (push)      mem[topPtr + PTR_W'(1)]  <= pushData;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: BOOT/RUN/HALT control, jump/branch/JR redirect, fault freeze, retire count.
// Latency: next pc registered on rising clk; pc_plus4/link_we/link_addr are combinational.
// Backpressure: stall holds pc and retired and drops redirects. Optional RAS via FETCH_RAS_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [BRANCH_IMM_W-1:0] branch_imm,
    input  logic                    jump,
    input  logic                    jump_link,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    input  logic                    jump_reg,
    input  logic [31:0]             reg_target,
    output logic [31:0]             pc,
    output logic [31:0]             pc_plus4,
    output logic                    link_we,
    output logic [31:0]             link_addr,
    output logic                    fault,
    output logic [31:0]             retired
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    fetchState_t state, stateNext;
    logic        active;
    logic [31:0] jrTarget;
    logic [31:0] candPc;
    logic        candBad;

    assign pc_plus4 = pc + 32'd4;
    assign active   = (state == RUN) && !stall;
    assign fault    = (state == HALT);

`ifdef FETCH_RAS_EN
    logic [31:0] rasTop;
    logic        rasEmpty;
    logic        rasFull;

    // JR prefers the predicted return address whenever one is stacked.
    assign jrTarget = rasEmpty ? reg_target : rasTop;

    fetch_ras #(.DEPTH(RAS_DEPTH)) uRas (
        .clk      (clk),
        .reset    (reset),
        .push     (link_we),
        .pop      (active && jump_reg && !rasEmpty),
        .pushData (pc_plus4),
        .top      (rasTop),
        .empty    (rasEmpty),
        .full     (rasFull)
    );
`else
    assign jrTarget = reg_target;
`endif

    // Redirect priority, link output, and the alignment/range check on the chosen target.
    always_comb begin
        link_we   = active && jump && jump_link;
        link_addr = pc_plus4;
        candPc    = pc_plus4;
        if (jump_reg)          candPc = jrTarget;
        else if (jump)         candPc = {pc_plus4[31:32-JUMP_HI_W], jump_index, 2'b00};
        else if (branch_taken) candPc = pc_plus4 + branchOffset(branch_imm);
        candBad = (candPc[1:0] != 2'b00) || (candPc >= IMEM_LIMIT);
    end

    // Next state: BOOT lasts one cycle, a bad target parks the unit in HALT until reset.
    always_comb begin
        stateNext = state;
        case (state)
            BOOT:    stateNext = RUN;
            RUN:     if (active && candBad) stateNext = HALT;
            HALT:    stateNext = HALT;
            default: stateNext = HALT;
        endcase
    end

    // State, pc and retire counter; pc only moves on an unstalled RUN cycle with a legal target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            state <= stateNext;
            if (active && !candBad) begin
                pc <= candPc;
                if (retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset/boot, JAL, branch+stall, priority, faults, async reset.
// Latency: inputs applied after a falling edge, outputs sampled on the next falling edge.
// Backpressure: exercised through the stall input.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic        jump_link;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        link_we;
    logic [31:0] link_addr;
    logic        fault;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_BYTES(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_link    (jump_link),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .link_we      (link_we),
        .link_addr    (link_addr),
        .fault        (fault),
        .retired      (retired)
    );

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; branch_imm = '0; jump = 0; jump_link = 0;
        jump_index = '0; jump_reg = 0; reg_target = '0;
    endtask

    // Leaves the DUT in RUN at pc 0, retired 0, just after a falling edge.
    task automatic reset_to_run();
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #1;
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        @(negedge clk);
        reset = 0;
        // BOOT cycle: a JAL here must be ignored.
        jump = 1; jump_link = 1; jump_index = 26'd6;
        #1;
        total++; if (link_we !== 1'b0) begin bad++; $display("FAIL boot_link_we got=%b exp=0", link_we); end
        @(negedge clk);
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL boot_hold_pc got=%h exp=%h", pc, 32'd0); end
        clear_inputs();
        @(negedge clk);
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL run_first_pc got=%h exp=%h", pc, 32'd4); end
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL run_first_retired got=%0d exp=1", retired); end
        total++; if (pc_plus4 !== 32'd8) begin bad++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, 32'd8); end
    endtask

    // Continues from pc 4 left by test_reset.
    task automatic test_jal_jr();
        logic [31:0] jrExp;
        jump = 1; jump_link = 1; jump_index = 26'd6;
        #1;
        total++; if (link_we !== 1'b1) begin bad++; $display("FAIL jal_link_we got=%b exp=1", link_we); end
        total++; if (link_addr !== 32'd8) begin bad++; $display("FAIL jal_link_addr got=%h exp=%h", link_addr, 32'd8); end
        @(negedge clk);
        total++; if (pc !== 32'd24) begin bad++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'd24); end
        clear_inputs();
        jump_link = 1;  // without jump: no link, no redirect
        #1;
        total++; if (link_we !== 1'b0) begin bad++; $display("FAIL lone_link_we got=%b exp=0", link_we); end
        @(negedge clk);
        total++; if (pc !== 32'd28) begin bad++; $display("FAIL lone_link_pc got=%h exp=%h", pc, 32'd28); end
        clear_inputs();
        jump_reg = 1; reg_target = 32'd0;
`ifdef FETCH_RAS_EN
        jrExp = 32'd8;
`else
        jrExp = 32'd0;
`endif
        @(negedge clk);
        total++; if (pc !== jrExp) begin bad++; $display("FAIL jr_return_pc got=%h exp=%h", pc, jrExp); end
        total++; if (retired !== 32'd4) begin bad++; $display("FAIL jr_retired got=%0d exp=4", retired); end
        clear_inputs();
    endtask

    task automatic test_branch_stall();
        reset_to_run();
        jump_reg = 1; reg_target = 32'd8;
        @(negedge clk);
        total++; if (pc !== 32'd8) begin bad++; $display("FAIL setup_pc8 got=%h exp=%h", pc, 32'd8); end
        clear_inputs();
        stall = 1; branch_taken = 1; branch_imm = 16'hFFFE; jump = 1; jump_link = 1;
        #1;
        total++; if (link_we !== 1'b0) begin bad++; $display("FAIL stall_link_we got=%b exp=0", link_we); end
        @(negedge clk);
        total++; if (pc !== 32'd8) begin bad++; $display("FAIL stall_pc got=%h exp=%h", pc, 32'd8); end
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL stall_retired got=%0d exp=1", retired); end
        clear_inputs();
        branch_taken = 1; branch_imm = 16'hFFFE;
        @(negedge clk);
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL branch_back_pc got=%h exp=%h", pc, 32'd4); end
        total++; if (retired !== 32'd2) begin bad++; $display("FAIL branch_retired got=%0d exp=2", retired); end
        branch_imm = 16'd2;
        @(negedge clk);
        total++; if (pc !== 32'd16) begin bad++; $display("FAIL branch_fwd_pc got=%h exp=%h", pc, 32'd16); end
        clear_inputs();
    endtask

    task automatic test_priority();
        reset_to_run();
        jump_reg = 1; reg_target = 32'd12; jump = 1; jump_index = 26'd6;
        branch_taken = 1; branch_imm = 16'd1;
        @(negedge clk);
        total++; if (pc !== 32'd12) begin bad++; $display("FAIL prio_jr_pc got=%h exp=%h", pc, 32'd12); end
        clear_inputs();
        jump = 1; jump_index = 26'd1; branch_taken = 1; branch_imm = 16'd3;
        @(negedge clk);
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL prio_jump_pc got=%h exp=%h", pc, 32'd4); end
        clear_inputs();
    endtask

    task automatic test_fault();
        reset_to_run();
        jump_reg = 1; reg_target = 32'h0000_0006;
        @(negedge clk);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL misalign_fault got=%b exp=1", fault); end
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL misalign_pc got=%h exp=%h", pc, 32'd0); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL misalign_retired got=%0d exp=0", retired); end
        clear_inputs();
        jump = 1; jump_link = 1; jump_index = 26'd2;
        #1;
        total++; if (link_we !== 1'b0) begin bad++; $display("FAIL halt_link_we got=%b exp=0", link_we); end
        @(negedge clk);
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL halt_pc got=%h exp=%h", pc, 32'd0); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", fault); end
        clear_inputs();
        // Async reset away from any clock edge clears HALT.
        #2 reset = 1;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL async_clear_fault got=%b exp=0", fault); end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        // Out-of-range target: 4 + 7*4 = 32 is at the memory limit.
        branch_taken = 1; branch_imm = 16'd7;
        @(negedge clk);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL range_fault got=%b exp=1", fault); end
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL range_pc got=%h exp=%h", pc, 32'd0); end
        clear_inputs();
    endtask

    task automatic test_async_reset_stall();
        reset_to_run();
        @(negedge clk);
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL pre_stall_retired got=%0d exp=1", retired); end
        stall = 1;
        @(negedge clk);
        #2 reset = 1;
        #1;
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL stall_reset_pc got=%h exp=%h", pc, 32'd0); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL stall_reset_retired got=%0d exp=0", retired); end
        @(negedge clk);
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 0;
        @(negedge clk);
        test_reset();
        test_jal_jr();
        test_branch_stall();
        test_priority();
        test_fault();
        test_async_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 32: instruction memory size in bytes; must be a power of two ≥ 8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1: hold PC this cycle.
REQ-006 SHALL have port branch_taken, input, 1: take a conditional branch.
REQ-007 SHALL have port branch_imm, input, 16: branch immediate, in words.
REQ-008 SHALL have port jump, input, 1: J/JAL absolute jump.
REQ-009 SHALL have port jump_link, input, 1: JAL; valid only with jump.
REQ-010 SHALL have port jump_index, input, 26: J-format target field.
REQ-011 SHALL have port jump_reg, input, 1: JR.
REQ-012 SHALL have port reg_target, input, 32: JR target byte address.
REQ-013 SHALL have port pc, output, 32: fetch address to instruction memory.
REQ-014 SHALL have port pc_plus4, output, 32: pc + 4, combinational.
REQ-015 SHALL have port link_we, output, 1: write link_addr to $ra this cycle.
REQ-016 SHALL have port link_addr, output, 32: return address.
REQ-017 SHALL have port fault, output, 1: sticky fetch fault; PC frozen.
REQ-018 SHALL have port retired, output, 32: count of advanced fetches.

Function
REQ-019 SHALL implement FSM states BOOT, RUN, HALT; reset enters BOOT, BOOT→RUN unconditionally next cycle, RUN→HALT on fault, HALT exits only via reset.
REQ-020 In BOOT, SHALL hold pc at RESET_PC, ignore all redirect inputs, and keep link_we low.
REQ-021 In RUN with stall high, SHALL hold pc and retired, drive link_we low, and drop redirects; the stall input takes priority over every redirect.
REQ-022 In RUN without stall, next pc priority: jump_reg → reg_target; else jump → {pc_plus4[31:28], jump_index, 2'b00}; else branch_taken → pc_plus4 + (sign_extend(branch_imm) << 2); else pc_plus4.
REQ-023 All address arithmetic SHALL be 32-bit modulo 2^32; no carry out.
REQ-024 link_we SHALL be combinational, equal to jump & jump_link & ~stall in RUN, with link_addr = pc_plus4.
REQ-025 A candidate next pc with bits[1:0] ≠ 0, or ≥ IMEM_BYTES, SHALL NOT be loaded: pc holds, fault sets next cycle, FSM → HALT.
REQ-026 In HALT, SHALL freeze pc and retired and hold link_we low.
REQ-027 retired SHALL increment by 1 on each RUN cycle where pc advances, saturating at 32'hFFFF_FFFF.
REQ-028 jump_link without jump SHALL be ignored.

Reset
REQ-029 Reset assertion SHALL immediately force pc=RESET_PC, fault=0, retired=0, state=BOOT, regardless of clk or current state, including mid-stall and HALT.
REQ-030 RESET_PC SHALL itself be aligned and < IMEM_BYTES; no fault check applies to it.

Configuration
REQ-031 With macro FETCH_RAS_EN defined, SHALL include a 4-entry return-address stack: JAL pushes pc_plus4 (overwrites oldest when full); JR pops and uses the stack top instead of reg_target when non-empty; when empty, JR uses reg_target.
REQ-032 Without FETCH_RAS_EN, SHALL contain no stack storage and JR always uses reg_target.

Structure
REQ-033 SHALL place FSM state typedef (BOOT/RUN/HALT), the RAS depth constant (4), and the jump-target field widths in a shared package fetch_pkg.
REQ-034 SHALL place the RAS in one sub-module fetch_ras (push, pop, top, empty, full), instantiated only under FETCH_RAS_EN.

Verification
REQ-035 Reset, then 2 free-running cycles → pc 0 (BOOT), then 0, then 4; retired=1.
REQ-036 At pc=4: jump=1, jump_link=1, jump_index=6 → next pc=24; link_we=1 and link_addr=8 in that cycle.
REQ-037 At pc=8: branch_taken=1, branch_imm=16'hFFFE → next pc=4; with stall=1 in the same cycle → pc stays 8 and retired unchanged.
REQ-038 jump_reg=1, reg_target=32'h0000_0006 → pc holds, fault=1 next cycle; further inputs ignored until reset clears fault.
REQ-039 jump_reg=1 with jump=1 and branch_taken=1, reg_target=12 → next pc=12 (priority check).
REQ-040 With FETCH_RAS_EN: JAL at pc 4 → target 24, then JR at 28 with reg_target=0 → next pc=8 (from the stack); without the macro → next pc=0.
